// File: rtl/fir_pkg.sv
// Shared constants, coefficients and fill-state encoding for the 10-tap FIR feeder.
package fir_pkg;

   localparam int unsigned NUM_TAPS = 10;
   localparam int unsigned SAMPLE_W = 4;
   localparam int unsigned Y_W      = 16;

   // Shift-add FIR coefficients, H[k] weights tap Xk
   localparam int unsigned H0 = 0;
   localparam int unsigned H1 = 1;
   localparam int unsigned H2 = 2;
   localparam int unsigned H3 = 3;
   localparam int unsigned H4 = 4;
   localparam int unsigned H5 = 5;
   localparam int unsigned H6 = 6;
   localparam int unsigned H7 = 7;
   localparam int unsigned H8 = 8;
   localparam int unsigned H9 = 9;

   typedef enum logic [1:0] {
      StEmpty   = 2'd0,
      StFilling = 2'd1,
      StPrimed  = 2'd2
   } fill_state_e;

   // Coefficient lookup by tap index
   function automatic int unsigned fir_coef(input int unsigned idx);
      case (idx)
         0:       return H0;
         1:       return H1;
         2:       return H2;
         3:       return H3;
         4:       return H4;
         5:       return H5;
         6:       return H6;
         7:       return H7;
         8:       return H8;
         9:       return H9;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/fir_fill_ctrl.sv
// Fill-state FSM and saturating fill counter for the FIR tap line.
// Generates the accept strobe, in_ready and taps_valid.
// FIR_TAP_ZERO_PAD_EN: when defined, taps_valid rises after the first accept
// (unfilled taps act as zero history) instead of waiting for a full window.
module fir_fill_ctrl
   import fir_pkg::*;
#(
   parameter int unsigned NUM_TAPS = 10,
   parameter int unsigned CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             hold,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             accept,
   output logic             taps_valid,
   output logic [CNT_W-1:0] fill_count
);

   localparam logic [CNT_W-1:0] CntFull = CNT_W'(NUM_TAPS);
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(NUM_TAPS - 1);

   fill_state_e state_q;

   // Ready is low during reset, stall or flush; independent of in_valid
   assign in_ready = rst_n & ~hold & ~clr;
   assign accept   = in_valid & in_ready;

   // Fill FSM, saturating counter and registered taps_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StEmpty;
         fill_count <= '0;
         taps_valid <= 1'b0;
      end else if (clr) begin
         state_q    <= StEmpty;
         fill_count <= '0;
         taps_valid <= 1'b0;
      end else if (accept) begin
         if (fill_count != CntFull) begin
            fill_count <= fill_count + 1'b1;
         end
         case (state_q)
            StEmpty: begin
               state_q <= StFilling;
`ifdef FIR_TAP_ZERO_PAD_EN
               taps_valid <= 1'b1;
`endif
            end
            StFilling: begin
               if (fill_count == CntLast) begin
                  state_q    <= StPrimed;
                  taps_valid <= 1'b1;
               end
            end
            StPrimed: begin
               state_q <= StPrimed;
            end
            default: begin
               state_q    <= StEmpty;
               fill_count <= '0;
               taps_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/fir_tap_line.sv
// 10-deep sample delay line feeding the shift-add FIR stage as parallel taps.
// X0 is the newest sample x[n], X9 the oldest x[n-9].
// FIR_TAP_ZERO_PAD_EN: when defined, taps_valid asserts once any sample is held.
module fir_tap_line
   import fir_pkg::*;
#(
   parameter int unsigned NUM_TAPS = 10,
   parameter int unsigned SAMPLE_W = 4,
   parameter int unsigned CNT_W    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                hold,
   input  logic [SAMPLE_W-1:0] in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [SAMPLE_W-1:0] X0,
   output logic [SAMPLE_W-1:0] X1,
   output logic [SAMPLE_W-1:0] X2,
   output logic [SAMPLE_W-1:0] X3,
   output logic [SAMPLE_W-1:0] X4,
   output logic [SAMPLE_W-1:0] X5,
   output logic [SAMPLE_W-1:0] X6,
   output logic [SAMPLE_W-1:0] X7,
   output logic [SAMPLE_W-1:0] X8,
   output logic [SAMPLE_W-1:0] X9,
   output logic                taps_valid,
   output logic [CNT_W-1:0]    fill_count
);

   logic                accept;
   logic [SAMPLE_W-1:0] taps_q [NUM_TAPS];

   fir_fill_ctrl #(
      .NUM_TAPS (NUM_TAPS),
      .CNT_W    (CNT_W)
   ) u_fill_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .hold       (hold),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .accept     (accept),
      .taps_valid (taps_valid),
      .fill_count (fill_count)
   );

   // Delay line: flush on clr, shift one place per accepted sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_TAPS; i++) taps_q[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < NUM_TAPS; i++) taps_q[i] <= '0;
      end else if (accept) begin
         for (int i = NUM_TAPS - 1; i > 0; i--) taps_q[i] <= taps_q[i-1];
         taps_q[0] <= in_data;
      end
   end

   assign X0 = taps_q[0];
   assign X1 = taps_q[1];
   assign X2 = taps_q[2];
   assign X3 = taps_q[3];
   assign X4 = taps_q[4];
   assign X5 = taps_q[5];
   assign X6 = taps_q[6];
   assign X7 = taps_q[7];
   assign X8 = taps_q[8];
   assign X9 = taps_q[9];

endmodule

// File: doc/fir_tap_line.md
Name: fir_tap_line

Overview:
Upstream feeder for the 10-tap shift-add FIR stage (without_multiplier_and_memory).
- Accepts a serial stream of 4-bit samples through a valid/ready handshake.
- Holds them in a 10-deep shift register and presents them as parallel taps X0..X9, with X0 the newest sample (x[n]) and X9 the oldest (x[n-9]).
- Qualifies the taps with taps_valid once the delay line is primed.

Parameters:
- NUM_TAPS, 10, delay-line depth; fixed by the FIR stage, only 10 supported.
- SAMPLE_W, 4, sample width in bits.
- CNT_W, 4, fill-counter width; must satisfy 2^CNT_W > NUM_TAPS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush; empties the line.
- hold  input  1  downstream stall; freezes the line.
- in_data  input  SAMPLE_W  incoming sample.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  line can accept a sample this cycle.
- X0..X9  output  SAMPLE_W each  tap registers; X0 is newest.
- taps_valid  output  1  X0..X9 form a complete window.
- fill_count  output  CNT_W  samples currently held, saturating at NUM_TAPS.

Behaviour:
- Reset (rst_n low, asynchronous):
  - X0..X9 = 0, fill_count = 0, taps_valid = 0.
  - FSM goes to EMPTY; in_ready = 0 while rst_n is low.
- in_ready = rst_n & ~hold & ~clr. It is combinational and does not depend on in_valid.
- Accept: a sample is accepted when in_valid & in_ready at a rising clk edge.
- Shift on accept, in the same edge:
  - X9 <= X8 ... X1 <= X0, X0 <= in_data.
  - The old X9 is discarded.
- Latency: an accepted sample appears on X0 one clk after the accept edge. Taps are registered outputs with no combinational path from in_data.
- fill_count increments by 1 per accept and saturates at NUM_TAPS (10). It never wraps.
- FSM states:
  - EMPTY: fill_count = 0. The first accept moves to FILLING.
  - FILLING: 0 < fill_count < 10. The accept that makes fill_count 10 moves to PRIMED.
  - PRIMED: fill_count = 10. Stays PRIMED on further accepts.
  - clr from any state goes to EMPTY.
- taps_valid = 1 in PRIMED only (registered, same edge as the state change).
  - The FIR output Y is meaningful only while taps_valid = 1.
- hold = 1: no shift, no count change, taps stay stable; in_valid is ignored.
- clr = 1 at an edge:
  - X0..X9 <= 0, fill_count <= 0, state <= EMPTY, taps_valid <= 0.
  - clr has priority over an accept; the sample is dropped, which is consistent with in_ready = 0.
- clr and hold both high: clr wins.
- in_valid low: no change. Gaps between samples are allowed.
- Reset asserted mid-fill or in PRIMED: immediate asynchronous clear to the reset values.
- Release of rst_n: the line resumes accepting on the first rising edge where rst_n is high.

Optional Feature:
- Macro: FIR_TAP_ZERO_PAD_EN.
- Defined:
  - Unfilled taps count as zero-padded history.
  - taps_valid goes to 1 one clk after the first accept, i.e. in FILLING and PRIMED.
  - taps_valid returns to 0 only on reset or clr.
- Undefined: taps_valid only in PRIMED, as described under Behaviour.
- fill_count behaves the same in both builds.

Decomposition:
- Shared package fir_pkg:
  - NUM_TAPS = 10, SAMPLE_W = 4, Y_W = 16.
  - Coefficient constants H0..H9 = 0..9.
  - FSM encoding: EMPTY = 2'd0, FILLING = 2'd1, PRIMED = 2'd2.
- One natural sub-module: fir_fill_ctrl.
  - Contents: the FSM plus the saturating fill counter.
  - Generates taps_valid and in_ready.
- The shift register stays in fir_tap_line.

Test Plan:
1. Reset and prime:
   - Stimulus: assert rst_n = 0, release it, then drive in_valid = 1 for 10 cycles with in_data = 1,2,...,10 (4'hA).
   - Response: after the 10th accept, X0..X9 = 10,9,...,1, fill_count = 10, taps_valid = 1. taps_valid is 0 after each of the first 9 accepts.
2. Wrap and discard:
   - Stimulus: continue from scenario 1 with in_data = 4'hF.
   - Response: X0 = 15, X9 = 2, the value 1 is discarded, fill_count stays 10.
3. Hold:
   - Stimulus: in PRIMED, assert hold = 1 for 3 cycles with in_valid = 1 and in_data = 7.
   - Response: in_ready = 0 and X0..X9, fill_count unchanged.
   - Stimulus: release hold.
   - Response: the next accept shifts in 7.
4. Flush:
   - Stimulus: with fill_count = 6, assert clr and in_valid = 1 together for one cycle.
   - Response: all taps = 0, fill_count = 0, state EMPTY, taps_valid = 0, and the sample is not captured.
5. Asynchronous reset mid-fill:
   - Stimulus: pulse rst_n low between clock edges after 4 accepts.
   - Response: outputs clear immediately, without waiting for a clk edge; refill then needs 10 new accepts.
6. Gappy input with FIR:
   - Stimulus: alternate in_valid 1/0 with all samples = 1.
   - Response: priming takes 19 cycles.
   - Chained to without_multiplier_and_memory, once primed, Y = 45 (sum of 0..9).
   - With FIR_TAP_ZERO_PAD_EN defined, taps_valid = 1 after the first accept, when Y = 0.
